// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
//   MMIO register bus for the seven-segment scan controller.
//
//   Handshake: a write is wr_en high for one clk_in cycle with addr and
//   wdata stable for that cycle. There is no ready/backpressure, so every
//   strobe is accepted on the rising edge where it is sampled. Reads have
//   no strobe: rdata follows addr combinationally.
//
//   Signals
//     wr_en  1   write strobe, one cycle per write
//     addr   4   register word index
//     wdata  32  write data (full word sampled)
//     rdata  32  combinational read data for addr
//
//   Modports
//     master : drives wr_en/addr/wdata, receives rdata (CPU / testbench side)
//     slave  : receives wr_en/addr/wdata, drives rdata (controller side)
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if;
    logic        wr_en;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output wr_en,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wr_en,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Multiplexed seven-segment display scanner with an MMIO register file.
//   One digit is driven per slot of DIV_CYCLES clocks; the scan index walks
//   0..NUM_DIGITS-1 and wraps. Segment content is either raw (1 = lit) or a
//   hex nibble decoded to segments. All display outputs are registered and
//   active-low.
//
//   Register map (word index on bus.addr)
//     0              CTRL   bit0 EN, bit1 HEX
//     1..NUM_DIGITS  DIGn   bit7 dp on, bits 6:0 raw segments / 3:0 nibble
//     15             BLINK  per-digit blink enables (SEG_BLINK_EN only)
//     others         read 0, writes ignored
//
//   Optional feature macro: SEG_BLINK_EN
//     Adds the BLINK register plus a blink counter whose phase bit toggles
//     every BLINK_CYCLES while EN=1. A digit with its BLINK bit set is
//     blanked (segments and dp off) during phase 1.
//
//   Parameters
//     NUM_DIGITS    number of digits, 1..8
//     DIV_CYCLES    clocks per digit slot, >= 2
//     BLINK_CYCLES  clocks per blink phase, >= 2 (used with SEG_BLINK_EN)
//
//   Ports
//     clk_in  in   sole clock, rising edge
//     reset   in   synchronous active-high reset, dominates bus writes
//     bus     if   seg_scan_ctrl_if.slave register bus
//     seg     out  7 segments {g,f,e,d,c,b,a}, active-low
//     dp      out  decimal point, active-low
//     digit   out  NUM_DIGITS one-hot active-low digit enables
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_CYCLES   = 1000,
    parameter int BLINK_CYCLES = 500000
) (
    input  logic                  clk_in,
    input  logic                  reset,
    seg_scan_ctrl_if.slave        bus,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit
);

    localparam int SLOT_W = $clog2(DIV_CYCLES);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Standard hex to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]                  ctrl_q,  ctrl_d;
    logic [NUM_DIGITS-1:0][7:0]  dig_q,   dig_d;
    logic [SLOT_W-1:0]           slot_q,  slot_d;
    logic [IDX_W-1:0]            idx_q,   idx_d;
    logic [6:0]                  seg_q,   seg_d;
    logic                        dp_q,    dp_d;
    logic [NUM_DIGITS-1:0]       digit_q, digit_d;

    logic en;
    logic hex_mode;
    assign en       = ctrl_q[0];
    assign hex_mode = ctrl_q[1];

`ifdef SEG_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [NUM_DIGITS-1:0] blink_q,  blink_d;
    logic [BLINK_W-1:0]    bcnt_q,   bcnt_d;
    logic                  phase_q,  phase_d;
`endif

    // ------------------------------------------------------------------
    // Register writes. Only the bits each register holds are kept; the
    // rest of wdata is discarded.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d = ctrl_q;
        dig_d  = dig_q;
`ifdef SEG_BLINK_EN
        blink_d = blink_q;
`endif
        if (bus.wr_en) begin
            if (bus.addr == 4'd0) begin
                ctrl_d = bus.wdata[1:0];
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (bus.addr == 4'(i + 1)) begin
                    dig_d[i] = bus.wdata[7:0];
                end
            end
`ifdef SEG_BLINK_EN
            if (bus.addr == 4'hF) begin
                blink_d = bus.wdata[NUM_DIGITS-1:0];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux.
    // ------------------------------------------------------------------
    logic [31:0] rdata_c;

    always_comb begin
        rdata_c = 32'h0;
        if (bus.addr == 4'd0) begin
            rdata_c = {30'h0, ctrl_q};
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.addr == 4'(i + 1)) begin
                rdata_c = {24'h0, dig_q[i]};
            end
        end
`ifdef SEG_BLINK_EN
        if (bus.addr == 4'hF) begin
            rdata_c = 32'(blink_q);
        end
`endif
    end

    assign bus.rdata = rdata_c;

    // ------------------------------------------------------------------
    // Slot counter and scan index. Both sit at 0 while EN=0, so setting EN
    // always begins at digit 0 with a full slot.
    // ------------------------------------------------------------------
    always_comb begin
        slot_d = slot_q;
        idx_d  = idx_q;
        if (!en) begin
            slot_d = '0;
            idx_d  = '0;
        end else if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            slot_d = slot_q + 1'b1;
        end
    end

`ifdef SEG_BLINK_EN
    // Blink phase runs off its own counter, independent of the slot timing.
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!en) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output pipeline: next display value from the current index, CTRL and
    // digit registers. A DIGn write landing on a slot wrap is therefore
    // visible at the following update.
    // ------------------------------------------------------------------
    logic [7:0] cur_dig;
    logic       cur_blank;

    always_comb begin
        cur_dig   = 8'h00;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig = dig_q[i];
`ifdef SEG_BLINK_EN
                cur_blank = blink_q[i] & phase_q;
`endif
            end
        end
    end

    always_comb begin
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        digit_d = '1;
        if (en) begin
            // Exactly one enable low, taken straight from the registered
            // index, so two digits are never active at once.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_d[i] = (idx_q != IDX_W'(i));
            end
            if (!cur_blank) begin
                seg_d = hex_mode ? hex_to_seg(cur_dig[3:0]) : ~cur_dig[6:0];
                dp_d  = ~cur_dig[7];
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            ctrl_q  <= '0;
            dig_q   <= '0;
            slot_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            digit_q <= '1;
`ifdef SEG_BLINK_EN
            blink_q <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            ctrl_q  <= ctrl_d;
            dig_q   <= dig_d;
            slot_q  <= slot_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            digit_q <= digit_d;
`ifdef SEG_BLINK_EN
            blink_q <= blink_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign digit = digit_q;

endmodule
